// File: rtl/demux_reg_16x_n.sv
// rtl/demux_reg_16x_n.sv - 16-entry register bank with addressed and append write demultiplexer
module demux_reg_16x_n #(
    parameter int BITS = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            zera,
    input  logic            escreve,
    input  logic            modo,
    input  logic [3:0]      SEL,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q0,
    output logic [BITS-1:0] Q1,
    output logic [BITS-1:0] Q2,
    output logic [BITS-1:0] Q3,
    output logic [BITS-1:0] Q4,
    output logic [BITS-1:0] Q5,
    output logic [BITS-1:0] Q6,
    output logic [BITS-1:0] Q7,
    output logic [BITS-1:0] Q8,
    output logic [BITS-1:0] Q9,
    output logic [BITS-1:0] Q10,
    output logic [BITS-1:0] Q11,
    output logic [BITS-1:0] Q12,
    output logic [BITS-1:0] Q13,
    output logic [BITS-1:0] Q14,
    output logic [BITS-1:0] Q15,
    output logic [3:0]      ponteiro,
    output logic [4:0]      conta,
    output logic            cheio,
    output logic            vazio,
    output logic            escrito,
    output logic            erro
);

    logic [BITS-1:0] mem_q [16];
    logic [BITS-1:0] mem_d [16];
    logic [3:0]      ptr_q, ptr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            escrito_q, escrito_d;
    logic            erro_q, erro_d;
    logic            full;

    assign full = (cnt_q == 5'd16);

    always_comb begin
        mem_d     = mem_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        escrito_d = 1'b0;
        erro_d    = 1'b0;
        if (zera) begin
            for (int i = 0; i < 16; i++) begin
                mem_d[i] = '0;
            end
            ptr_d = 4'd0;
            cnt_d = 5'd0;
        end else if (escreve) begin
            if (!modo) begin
                mem_d[SEL] = D;
                escrito_d  = 1'b1;
            end else if (!full) begin
                // pointer wraps to 0 on the 16th append while conta reaches 16
                mem_d[ptr_q] = D;
                ptr_d        = ptr_q + 4'd1;
                cnt_d        = cnt_q + 5'd1;
                escrito_d    = 1'b1;
            end else begin
                erro_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q     <= 4'd0;
            cnt_q     <= 5'd0;
            escrito_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            escrito_q <= escrito_d;
            erro_q    <= erro_d;
        end
    end

    assign Q0       = mem_q[0];
    assign Q1       = mem_q[1];
    assign Q2       = mem_q[2];
    assign Q3       = mem_q[3];
    assign Q4       = mem_q[4];
    assign Q5       = mem_q[5];
    assign Q6       = mem_q[6];
    assign Q7       = mem_q[7];
    assign Q8       = mem_q[8];
    assign Q9       = mem_q[9];
    assign Q10      = mem_q[10];
    assign Q11      = mem_q[11];
    assign Q12      = mem_q[12];
    assign Q13      = mem_q[13];
    assign Q14      = mem_q[14];
    assign Q15      = mem_q[15];
    assign ponteiro = ptr_q;
    assign conta    = cnt_q;
    assign cheio    = full;
    assign vazio    = (cnt_q == 5'd0);
    assign escrito  = escrito_q;
    assign erro     = erro_q;

endmodule

// File: tb/tb_demux_reg_16x_n.sv
// tb/tb_demux_reg_16x_n.sv - self-checking bench for demux_reg_16x_n
module tb_demux_reg_16x_n;

    localparam int BITS = 4;

    logic            clock = 1'b0;
    logic            reset, zera, escreve, modo;
    logic [3:0]      SEL;
    logic [BITS-1:0] D;
    logic [BITS-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [BITS-1:0] Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
    logic [3:0]      ponteiro;
    logic [4:0]      conta;
    logic            cheio, vazio, escrito, erro;

    demux_reg_16x_n #(.BITS(BITS)) dut (
        .clock(clock), .reset(reset), .zera(zera), .escreve(escreve),
        .modo(modo), .SEL(SEL), .D(D),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .Q8(Q8), .Q9(Q9), .Q10(Q10), .Q11(Q11), .Q12(Q12), .Q13(Q13),
        .Q14(Q14), .Q15(Q15),
        .ponteiro(ponteiro), .conta(conta), .cheio(cheio), .vazio(vazio),
        .escrito(escrito), .erro(erro)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0][BITS-1:0] mem;
        logic [3:0]            ptr;
        logic [4:0]            cnt;
        logic                  full, empty, wr, err;
    } exp_t;

    typedef struct {
        logic       z, e, m;
        logic [3:0] s;
        logic [3:0] d;
        logic [4:0] e_cnt;
        logic [3:0] e_ptr;
        logic       e_wr, e_err;
    } vec_t;

    exp_t                  sbq[$];
    logic [15:0][BITS-1:0] m_mem;
    logic [3:0]            m_ptr;
    logic [4:0]            m_cnt;
    logic                  m_wr, m_err;
    logic [16*BITS-1:0]    q_all;
    int                    n_chk = 0;
    int                    n_fail = 0;
    vec_t                  tbl[8];

    assign q_all = {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic z, input logic e, input logic m,
                         input logic [3:0] s, input logic [3:0] dd);
        exp_t x;
        m_wr  = 1'b0;
        m_err = 1'b0;
        if (r || z) begin
            m_mem = '0;
            m_ptr = 4'd0;
            m_cnt = 5'd0;
        end else if (e) begin
            if (!m) begin
                m_mem[s] = dd;
                m_wr     = 1'b1;
            end else if (m_cnt < 5'd16) begin
                m_mem[m_ptr] = dd;
                m_ptr        = m_ptr + 4'd1;
                m_cnt        = m_cnt + 5'd1;
                m_wr         = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        x.mem   = m_mem;
        x.ptr   = m_ptr;
        x.cnt   = m_cnt;
        x.full  = (m_cnt == 5'd16);
        x.empty = (m_cnt == 5'd0);
        x.wr    = m_wr;
        x.err   = m_err;
        sbq.push_back(x);
    endtask

    task automatic step(input logic r, input logic z, input logic e, input logic m,
                        input logic [3:0] s, input logic [3:0] dd);
        exp_t x;
        reset = r; zera = z; escreve = e; modo = m; SEL = s; D = dd;
        model(r, z, e, m, s, dd);
        @(posedge clock);
        #1;
        x = sbq.pop_front();
        chk("q_bank", 64'(q_all), 64'(x.mem));
        chk("ponteiro", 64'(ponteiro), 64'(x.ptr));
        chk("conta", 64'(conta), 64'(x.cnt));
        chk("cheio", 64'(cheio), 64'(x.full));
        chk("vazio", 64'(vazio), 64'(x.empty));
        chk("escrito", 64'(escrito), 64'(x.wr));
        chk("erro", 64'(erro), 64'(x.err));
    endtask

    task automatic append(input logic [3:0] dd);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, dd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{z:0, e:1, m:1, s:4'd0, d:4'd1, e_cnt:5'd1, e_ptr:4'd1, e_wr:1, e_err:0};
        tbl[1] = '{z:0, e:1, m:1, s:4'd9, d:4'd2, e_cnt:5'd2, e_ptr:4'd2, e_wr:1, e_err:0};
        tbl[2] = '{z:0, e:1, m:1, s:4'd0, d:4'd3, e_cnt:5'd3, e_ptr:4'd3, e_wr:1, e_err:0};
        tbl[3] = '{z:0, e:0, m:1, s:4'd0, d:4'd8, e_cnt:5'd3, e_ptr:4'd3, e_wr:0, e_err:0};
        tbl[4] = '{z:0, e:1, m:0, s:4'd12, d:4'd6, e_cnt:5'd3, e_ptr:4'd3, e_wr:1, e_err:0};
        tbl[5] = '{z:0, e:1, m:1, s:4'd0, d:4'd4, e_cnt:5'd4, e_ptr:4'd4, e_wr:1, e_err:0};
        tbl[6] = '{z:1, e:1, m:1, s:4'd0, d:4'd7, e_cnt:5'd0, e_ptr:4'd0, e_wr:0, e_err:0};
        tbl[7] = '{z:0, e:0, m:0, s:4'd0, d:4'd0, e_cnt:5'd0, e_ptr:4'd0, e_wr:0, e_err:0};

        reset = 1'b1; zera = 1'b0; escreve = 1'b0; modo = 1'b0; SEL = 4'd0; D = '0;
        m_mem = '0; m_ptr = 4'd0; m_cnt = 5'd0; m_wr = 1'b0; m_err = 1'b0;

        // reset then hold
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) idle();
        chk("rst_q_all", 64'(q_all), 64'd0);
        chk("rst_vazio", 64'(vazio), 64'd1);

        // table: appends 1,2,3, idle, addressed write, append, zera+escreve
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].z, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].d);
            chk($sformatf("tbl%0d_conta", i), 64'(conta), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ptr", i), 64'(ponteiro), 64'(tbl[i].e_ptr));
            chk($sformatf("tbl%0d_escrito", i), 64'(escrito), 64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_erro", i), 64'(erro), 64'(tbl[i].e_err));
            if (i == 2) chk("tbl_q012", 64'({Q2, Q1, Q0}), 64'h321);
        end
        chk("zera_q_all", 64'(q_all), 64'd0);

        // fill the bank, then a rejected 17th append
        for (int k = 0; k < 16; k++) append(4'(k));
        chk("full_q_all", 64'(q_all), 64'hFEDCBA9876543210);
        chk("full_conta", 64'(conta), 64'd16);
        chk("full_ptr", 64'(ponteiro), 64'd0);
        chk("full_cheio", 64'(cheio), 64'd1);
        append(4'd9);
        chk("rej_erro", 64'(erro), 64'd1);
        chk("rej_escrito", 64'(escrito), 64'd0);
        chk("rej_q0", 64'(Q0), 64'd0);
        idle();
        chk("rej_erro_pulse", 64'(erro), 64'd0);

        // addressed write while full
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'hA);
        chk("addr_q5", 64'(Q5), 64'hA);
        chk("addr_conta", 64'(conta), 64'd16);
        chk("addr_ptr", 64'(ponteiro), 64'd0);
        chk("addr_escrito", 64'(escrito), 64'd1);

        // zera with simultaneous write after 4 appends
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < 4; k++) append(4'(k + 11));
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd7);
        chk("zw_q_all", 64'(q_all), 64'd0);
        chk("zw_conta", 64'(conta), 64'd0);
        chk("zw_escrito", 64'(escrito), 64'd0);

        // reset mid-burst, then append lands in Q0
        for (int k = 0; k < 6; k++) append(4'(k + 2));
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9);
        chk("mid_q_all", 64'(q_all), 64'd0);
        chk("mid_conta", 64'(conta), 64'd0);
        append(4'd5);
        chk("post_q0", 64'(Q0), 64'd5);
        chk("post_conta", 64'(conta), 64'd1);
        chk("post_ptr", 64'(ponteiro), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_reg_16x_n.md
Name: demux_reg_16x_n

Overview:
16-entry, BITS-wide register bank with a write-side demultiplexer. A single input word is steered into one of 16 storage registers, either by explicit address or by an auto-incrementing append pointer. Q0..Q15 are registered outputs that drive the D0..D15 inputs of a 16:1 read mux. It stores the game-sequence entries for the SGA datapath.

Parameters:
BITS, 4, width of each stored entry and of the data input.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high; clears all state.
zera  input  1  synchronous clear of entries, pointer and flags. Same effect as reset.
escreve  input  1  write strobe; one write per cycle while high.
modo  input  1  0 = write entry SEL; 1 = append at ponteiro.
SEL  input  4  target entry in modo=0; ignored in modo=1.
D  input  BITS  data to store.
Q0..Q15  output  BITS each  registered contents of entries 0..15.
ponteiro  output  4  next append slot, 0..15.
conta  output  5  number of appended entries, 0..16.
cheio  output  1  high when conta==16.
vazio  output  1  high when conta==0.
escrito  output  1  one-cycle pulse, the cycle after a write is accepted.
erro  output  1  one-cycle pulse, the cycle after an append is rejected because the bank is full.

Behaviour:
- Reset values (after reset or zera): Q0..Q15=0, ponteiro=0, conta=0, vazio=1, cheio=0, escrito=0, erro=0.
- Priority at each edge: reset > zera > escreve. When zera and escreve are both high, the write is dropped and escrito stays 0.
- Write latency: with escreve=1 at edge N, the target Qk holds D from just after edge N. escrito is high during the cycle after edge N only.
- modo=0 (addressed write):
  - Qk <= D where k=SEL. All other entries hold.
  - ponteiro, conta and flags are unchanged.
  - Always accepted, including when cheio=1.
- modo=1 (append):
  - If conta<16: Q[ponteiro] <= D, conta <= conta+1, ponteiro <= ponteiro+1 mod 16.
  - When the 16th append is accepted, ponteiro wraps to 0 and conta=16, so cheio=1.
  - If conta==16: no entry changes, ponteiro and conta hold, escrito=0, erro pulses for one cycle.
- Continuous escreve=1 performs one write per clock; no handshake wait states.
- cheio and vazio are combinational decodes of registered conta, so they are glitch-free relative to clock.
- escreve=0: all state holds; escrito=0, erro=0.
- Only reset or zera clears entries. Reset mid-sequence discards every entry regardless of pointer.
- No read port: reads happen externally through the 16:1 mux on Q0..Q15.
- Unknown SEL values do not exist (4 bits address all 16 entries). No default path is needed.

Test Plan:
1. Reset, then hold 3 cycles -> all Q=0, ponteiro=0, conta=0, vazio=1, cheio=0, escrito=0, erro=0.
2. modo=1, append D=1,2,3 on consecutive cycles -> Q0=1, Q1=2, Q2=3; ponteiro=3; conta=3; vazio=0; escrito high on each of the 3 following cycles.
3. Append 16 values D=k for k=0..15, then a 17th with D=9 -> Qk=k; ponteiro=0; conta=16; cheio=1. The 17th leaves Q0=0, produces erro for one cycle and escrito=0.
4. With bank full, modo=0, SEL=5, D=0xA -> Q5=0xA; conta=16 and ponteiro=0 unchanged; escrito pulses.
5. After 4 appends, assert zera and escreve (modo=1, D=7) in the same cycle -> all Q=0, conta=0, ponteiro=0, escrito=0.
6. Reset asserted mid-append burst (after 6 writes) -> next cycle all Q=0 and conta=0. A following append writes Q0.
